alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Control FSM directly upstream of the ALU datapath. Accepts one op request
//  (opcode + two 16-bit operands) via start/busy/done handshake.
//  Drives the ALU's operand buses and strobes (a_enable, acc_enable, addsub,
//  xor_ctrl, mul_out_ctrl) in the correct cycle order.
//  Captures acc_out / mul_acc_out into a held result register.
// PARAMETERS
//  WIDTH  16  datapath width; operand, ALU bus and result width
//  OPW    2   opcode width
// PORTS
//  clk          in   1      single clock; all state updates on posedge clk
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request strobe; sampled only in IDLE
//  opcode       in   OPW    00 ADD, 01 SUB, 10 XOR, 11 MUL
//  operand_a    in   WIDTH  A operand
//  operand_b    in   WIDTH  B operand
//  alu_a        out  WIDTH  to ALU a
//  alu_b        out  WIDTH  to ALU b
//  alu_addsub   out  1      to ALU addsub (1 = subtract)
//  alu_xor      out  1      to ALU xor_ctrl
//  alu_mul      out  1      to ALU mul_out_ctrl
//  alu_a_en     out  1      to ALU a_enable
//  alu_acc_en   out  1      to ALU acc_enable
//  alu_acc      in   WIDTH  from ALU acc_out
//  alu_mul_acc  in   WIDTH  from ALU mul_acc_out
//  busy         out  1      high in every state except IDLE
//  done         out  1      one-cycle pulse; result valid from this cycle on
//  result_lo    out  WIDTH  captured alu_acc
//  result_hi    out  WIDTH  captured alu_mul_acc for MUL; 0 for other ops
// BEHAVIOUR
//  States (one-hot or binary; encoding is free):
//    IDLE -> LOAD_A -> EXEC -> CAPTURE -> DONE -> IDLE
//  IDLE:    start=1 latches opcode, operand_a, operand_b; next state LOAD_A.
//           start=0 stays in IDLE.
//  LOAD_A:  alu_a = latched A; alu_a_en=1.
//  EXEC:    alu_b = latched B; alu_acc_en=1; op strobes decoded:
//             ADD  addsub=0 xor=0 mul=0
//             SUB  addsub=1 xor=0 mul=0
//             XOR  addsub=0 xor=1 mul=0
//             MUL  addsub=0 xor=0 mul=1
//  CAPTURE: result_lo <= alu_acc; result_hi <= (MUL ? alu_mul_acc : 0).
//  DONE:    done=1 for exactly one cycle.
//  Latency: start sampled at edge N -> done high during cycle N+4.
//  Next start is accepted at edge N+5.
//  Strobes are 0 in every state except the one listed above.
//  alu_a / alu_b hold the latched values at all times (no bubbles to X).
//  start while busy=1: ignored; no queueing; latched operands unchanged.
//  Operands may change freely after the sampling edge.
//  result_lo / result_hi hold their value until the next CAPTURE.
//  Arithmetic wraps modulo 2^WIDTH; the ALU provides no carry/overflow,
//  and this block reports none.
//  rst=1 (any state, including mid-EXEC): next edge -> IDLE.
//    All outputs, latched operands and results become 0.
//    An aborted op never asserts done.
// CONFIGURATION
//  ALU_SEQ_CHAIN_EN defined:
//    Adds input port `chain` (1 bit), sampled with start.
//    chain=1: latched A = current result_lo instead of operand_a
//    (accumulate-style chaining).
//  ALU_SEQ_CHAIN_EN undefined:
//    No `chain` port; A always comes from operand_a.
// STRUCTURE
//  Shared include alu_seq_defs.vh:
//    opcode localparams OP_ADD/OP_SUB/OP_XOR/OP_MUL and state encodings.
//    Shared with the instruction decoder.
//  Result and operand latches: existing sixteen_bit_reg instances.
//  FSM: inline; no further sub-module.
// TESTING (bench uses a behavioural ALU model: acc = low word, mul_acc = high word)
//  ADD 0x0003 + 0x0005 -> done at cycle N+4; result_lo=0x0008, result_hi=0x0000.
//  SUB 0x0005 - 0x0007 -> alu_addsub=1 only in EXEC; result_lo=0xFFFE.
//  XOR 0xF0F0 ^ 0x0FF0 -> alu_xor=1 only in EXEC; result_lo=0xFF00.
//  MUL 0x1234 * 0x0100 -> result_hi=0x0012, result_lo=0x3400.
//  start pulsed during EXEC with new operands -> ignored; first op's result,
//    single done pulse.
//  rst in EXEC -> IDLE next cycle, outputs 0, no done.
//  Chain (macro on): ADD 2+3, then chained ADD +4 -> result_lo=0x0009.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_sequencer_pkg : opcodes, FSM states and strobe decode shared by the   |
// |                     ALU sequencer and the instruction decoder.            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_sequencer_pkg;

  localparam int C_OP_BITS = 2;

  typedef enum logic [C_OP_BITS-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_MUL = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic addsub;
    logic xor_c;
    logic mul;
  } strobes_t;

  // Exactly one of the three ALU mode strobes (or none, for ADD) per opcode.
  function automatic strobes_t decode_op(input opcode_e op);
    strobes_t s;
    s = '0;
    unique case (op)
      OP_SUB:  s.addsub = 1'b1;
      OP_XOR:  s.xor_c  = 1'b1;
      OP_MUL:  s.mul    = 1'b1;
      default: s        = '0;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | alu_sequencer_if : request handshake plus ALU control/result bus.         |
// | The chain input exists only when ALU_SEQ_CHAIN_EN is defined.             |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
);

  logic             start;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic             chain;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_addsub;
  logic             alu_xor;
  logic             alu_mul;
  logic             alu_a_en;
  logic             alu_acc_en;
  logic [WIDTH-1:0] alu_acc;
  logic [WIDTH-1:0] alu_mul_acc;

  modport slave (
`ifdef ALU_SEQ_CHAIN_EN
    input  chain,
`endif
    input  start, opcode, operand_a, operand_b, alu_acc, alu_mul_acc,
    output busy, done, result_lo, result_hi,
    output alu_a, alu_b, alu_addsub, alu_xor, alu_mul, alu_a_en, alu_acc_en
  );

  modport master (
`ifdef ALU_SEQ_CHAIN_EN
    output chain,
`endif
    output start, opcode, operand_a, operand_b, alu_acc, alu_mul_acc,
    input  busy, done, result_lo, result_hi,
    input  alu_a, alu_b, alu_addsub, alu_xor, alu_mul, alu_a_en, alu_acc_en
  );

endinterface

`default_nettype wire

// File: rtl/alu_sequencer_reg.sv
// +--------------------------------------------------------------------------+
// | sixteen_bit_reg : load-enabled register with synchronous clear, used for  |
// |                   operand and result latches.                             |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module sixteen_bit_reg #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en_i,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +--------------------------------------------------------------------------+
// | alu_sequencer : control FSM sequencing one op request through the ALU     |
// |                 (LOAD_A, EXEC, CAPTURE, DONE). Option: ALU_SEQ_CHAIN_EN.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
) (
  input wire logic      clk,
  input wire logic      rst,
  alu_sequencer_if.slave seq_io
);

  state_e           state_q, state_d;
  opcode_e          op_q, op_d;
  strobes_t         strb;
  logic             accept;
  logic             capture;
  logic             busy;
  logic             done;
  logic             a_en;
  logic             acc_en;
  logic [WIDTH-1:0] a_d, a_q, b_q;
  logic [WIDTH-1:0] lo_q, hi_d, hi_q;

  assign accept = (state_q == ST_IDLE) && seq_io.start;
  assign op_d   = opcode_e'(seq_io.opcode[C_OP_BITS-1:0]);

`ifdef ALU_SEQ_CHAIN_EN
  // Chaining feeds the previous low result back as the new A operand.
  assign a_d = seq_io.chain ? lo_q : seq_io.operand_a;
`else
  assign a_d = seq_io.operand_a;
`endif

  assign hi_d = (op_q == OP_MUL) ? seq_io.alu_mul_acc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= op_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    a_en    = 1'b0;
    acc_en  = 1'b0;
    capture = 1'b0;
    strb    = '0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (seq_io.start) begin
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        a_en    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        acc_en  = 1'b1;
        strb    = decode_op(op_q);
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  sixteen_bit_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (accept),
    .d_i  (a_d),
    .q_o  (a_q)
  );

  sixteen_bit_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (accept),
    .d_i  (seq_io.operand_b),
    .q_o  (b_q)
  );

  sixteen_bit_reg #(.WIDTH(WIDTH)) u_lo_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (capture),
    .d_i  (seq_io.alu_acc),
    .q_o  (lo_q)
  );

  sixteen_bit_reg #(.WIDTH(WIDTH)) u_hi_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (capture),
    .d_i  (hi_d),
    .q_o  (hi_q)
  );

  assign seq_io.busy       = busy;
  assign seq_io.done       = done;
  assign seq_io.alu_a      = a_q;
  assign seq_io.alu_b      = b_q;
  assign seq_io.alu_a_en   = a_en;
  assign seq_io.alu_acc_en = acc_en;
  assign seq_io.alu_addsub = strb.addsub;
  assign seq_io.alu_xor    = strb.xor_c;
  assign seq_io.alu_mul    = strb.mul;
  assign seq_io.result_lo  = lo_q;
  assign seq_io.result_hi  = hi_q;

endmodule

`default_nettype wire
